// File: rtl/sleep_cycle_controller.sv
// sleep_cycle_controller: awake/drowsy/asleep tracker driving energy counter enables; optional STRESS_WAKE_EN adds stress-forced wake.
module sleep_cycle_controller #(
  parameter int IND_W        = 2,
  parameter int SLEEP_LEVEL  = 0,
  parameter int WAKE_LEVEL   = 2**IND_W-1,
  parameter int STRESS_BLOCK = 2**IND_W-1,
  parameter int DROWSY_TICKS = 4,
  parameter int MIN_SLEEP    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [IND_W-1:0] energy_indicator,
  input  logic [IND_W-1:0] stress_indicator,
  output logic [1:0]       state,
  output logic             asleep,
  output logic             fell_asleep,
  output logic             woke_up,
  output logic             en_inc,
  output logic             en_dec
);
  localparam int CNT_MAX = DROWSY_TICKS > MIN_SLEEP ? DROWSY_TICKS : MIN_SLEEP;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [IND_W-1:0] SL = IND_W'(SLEEP_LEVEL);
  localparam logic [IND_W-1:0] WL = IND_W'(WAKE_LEVEL);
  localparam logic [IND_W-1:0] SB = IND_W'(STRESS_BLOCK);
  localparam logic [CW-1:0] DT_LAST = CW'(DROWSY_TICKS - 1);
  localparam logic [CW-1:0] MS = CW'(MIN_SLEEP);
  typedef enum logic [1:0] {AWAKE = 2'b00, DROWSY = 2'b01, ASLEEP = 2'b10} state_t;
  state_t st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic fell_nx, woke_nx, sleepy, block, wake_ok;
  assign sleepy  = energy_indicator <= SL;
  assign block   = stress_indicator >= SB;
  assign wake_ok = energy_indicator >= WL;
  always_comb begin
    st_nx   = st;
    cnt_nx  = cnt;
    fell_nx = 1'b0;
    woke_nx = 1'b0;
    case (st)
      AWAKE: if (tick && sleepy && !block) begin
        st_nx  = DROWSY;
        cnt_nx = '0;
      end
      DROWSY: if (tick) begin
        if (block || !sleepy) st_nx = AWAKE;
        else if (cnt == DT_LAST) begin
          st_nx   = ASLEEP;
          cnt_nx  = '0;
          fell_nx = 1'b1;
        end else cnt_nx = cnt + CW'(1);
      end
      ASLEEP: if (tick) begin
`ifdef STRESS_WAKE_EN
        if (block) begin
          st_nx   = AWAKE;
          woke_nx = 1'b1;
        end else
`endif
        if (cnt == MS && wake_ok) begin
          st_nx   = AWAKE;
          woke_nx = 1'b1;
        end else cnt_nx = (cnt == MS) ? cnt : cnt + CW'(1);
      end
      // reserved code: recover without waiting for a tick
      default: begin
        st_nx  = AWAKE;
        cnt_nx = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st          <= AWAKE;
      cnt         <= '0;
      fell_asleep <= 1'b0;
      woke_up     <= 1'b0;
    end else begin
      st          <= st_nx;
      cnt         <= cnt_nx;
      fell_asleep <= fell_nx;
      woke_up     <= woke_nx;
    end
  end
  assign state  = st;
  assign asleep = st == ASLEEP;
  assign en_dec = rst_n & tick & (st == AWAKE);
  assign en_inc = rst_n & tick & (st == ASLEEP);
endmodule

// File: tb/tb_sleep_cycle_controller.sv
// tb_sleep_cycle_controller: randomized stimulus, phase/elapsed-tick reference model, queue scoreboard.
module tb_sleep_cycle_controller;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
  logic [1:0] energy_indicator = '0, stress_indicator = '0;
  logic [1:0] state;
  logic asleep, fell_asleep, woke_up, en_inc, en_dec;
  sleep_cycle_controller dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .energy_indicator(energy_indicator), .stress_indicator(stress_indicator),
    .state(state), .asleep(asleep), .fell_asleep(fell_asleep), .woke_up(woke_up),
    .en_inc(en_inc), .en_dec(en_dec)
  );
  always #5 clk = ~clk;
  logic [6:0] exp_q[$];
  int tests = 0, fails = 0;
  // phase: 0 awake, 1 drowsy, 2 asleep; n: ticks elapsed in the current phase (unbounded)
  int phase = 0, n = 0;
  bit fell_m = 0, woke_m = 0, valid = 0;
  initial begin : monitor
    logic [6:0] e, o;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = {state, asleep, fell_asleep, woke_up, en_inc, en_dec};
        tests++;
        if (o !== e) begin
          fails++;
          $display("FAIL outputs t=%0t {state,asleep,fell,woke,inc,dec} got %b required %b", $time, o, e);
        end
      end
    end
  end
  initial begin : stimulus
    int ev, sv;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #2;
      rst_n = (c < 3) ? 1'b0 : ($urandom_range(0, 199) != 0);
      tick = (c < 3) ? 1'b1 : ($urandom_range(0, 9) < 6);
      if (c < 3) ev = 0;
      else if (phase == 0) ev = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(0, 3));
      else if (phase == 1) ev = ($urandom_range(0, 9) < 9) ? 0 : int'($urandom_range(1, 3));
      else ev = ($urandom_range(0, 3) == 0) ? 3 : int'($urandom_range(0, 2));
      sv = ($urandom_range(0, 99) < 8) ? 3 : int'($urandom_range(0, 2));
      energy_indicator = 2'(ev);
      stress_indicator = 2'(sv);
      if (valid)
        exp_q.push_back({2'(phase), phase == 2, fell_m, woke_m,
                         rst_n && tick && phase == 2, rst_n && tick && phase == 0});
      fell_m = 0;
      woke_m = 0;
      if (!rst_n) begin
        phase = 0;
        n = 0;
        valid = 1;
      end else if (tick) begin
        if (phase == 0) begin
          if (ev <= 0 && sv < 3) begin phase = 1; n = 0; end
        end else if (phase == 1) begin
          if (sv >= 3 || ev > 0) phase = 0;
          else begin
            n++;
            if (n == 4) begin phase = 2; n = 0; fell_m = 1; end
          end
        end else begin
          n++;
`ifdef STRESS_WAKE_EN
          if (sv >= 3) begin phase = 0; woke_m = 1; end else
`endif
          if (n >= 9 && ev >= 3) begin phase = 0; woke_m = 1; end
        end
      end
    end
    @(posedge clk);
    #2;
    tick = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sleep_cycle_controller.md
# sleep_cycle_controller

Parametrised successor to the physical state controller in the moody-mimosa core. Tracks the plant's awake/drowsy/asleep cycle from an energy and a stress indicator, advanced by a slow time-base tick. Drives the increment/decrement enables of the external energy counter and emits one-cycle fell-asleep and woke-up events to the mood logic. New relative to the previous generation:
- generic indicator width
- a drowsy phase with abort
- a minimum sleep duration
- an optional stress-forced wake

## Interface
Parameters:
- IND_W, 2: width of energy and stress indicators
- SLEEP_LEVEL, 0: energy at or below this level starts drowsiness
- WAKE_LEVEL, 2**IND_W-1: energy at or above this level allows waking
- STRESS_BLOCK, 2**IND_W-1: stress at or above this level blocks or aborts falling asleep
- DROWSY_TICKS, 4: ticks spent drowsy before sleep; must be ≥1
- MIN_SLEEP, 8: completed ASLEEP ticks required before waking is allowed; must be ≥0

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- tick  in  1  time-base enable; one-cycle pulse
- energy_indicator  in  IND_W  current energy level, unsigned
- stress_indicator  in  IND_W  current stress level, unsigned
- state  out  2  00 AWAKE, 01 DROWSY, 10 ASLEEP
- asleep  out  1  state==ASLEEP
- fell_asleep  out  1  one-cycle pulse on entry to ASLEEP
- woke_up  out  1  one-cycle pulse on ASLEEP→AWAKE
- en_inc  out  1  energy counter increment enable
- en_dec  out  1  energy counter decrement enable

## Operation
- Internal saturating counter `cnt`, width $clog2(max(DROWSY_TICKS,MIN_SLEEP)+1).
- All state and counter updates occur only on cycles with tick=1. With tick=0, state and cnt hold.
- All comparisons are unsigned.
- The reserved `state` code 11 is unreachable; if it is ever decoded, the next cycle returns to AWAKE.

AWAKE:
- If energy ≤ SLEEP_LEVEL and stress < STRESS_BLOCK: go to DROWSY, cnt←0.

DROWSY, checked in priority order:
1. If stress ≥ STRESS_BLOCK or energy > SLEEP_LEVEL: abort to AWAKE.
2. Else if cnt == DROWSY_TICKS-1: go to ASLEEP, cnt←0, fell_asleep←1.
3. Else cnt←cnt+1.
- ASLEEP is therefore reached on the DROWSY_TICKS-th tick after entering DROWSY.

ASLEEP:
- If cnt == MIN_SLEEP and energy ≥ WAKE_LEVEL: go to AWAKE, woke_up←1.
- Else cnt←min(cnt+1, MIN_SLEEP).
- Earliest wake is the (MIN_SLEEP+1)-th tick spent in ASLEEP.

Outputs:
- en_dec = tick & (state==AWAKE), combinational.
- en_inc = tick & (state==ASLEEP), combinational.
- DROWSY asserts neither enable. en_inc and en_dec are never high together.
- fell_asleep and woke_up are registered. Each is high for exactly the one cycle following the transitioning tick, and is cleared on the next clock regardless of tick.
- asleep is decoded from the state register.

Boundary behaviour:
- Simultaneous abort and sleep conditions in DROWSY: abort wins.
- Indicator changes between ticks are ignored; only values sampled at tick matter.
- Back-to-back ticks (tick held high) are legal: one evaluation per cycle.

## Timing
- Reset: rst_n=0 sampled on a clk edge gives state=AWAKE, cnt=0, fell_asleep=0, woke_up=0. asleep follows state and reads 0. en_inc/en_dec also read 0 while rst_n=0, even if tick=1.
- Reset asserted mid-sleep or mid-drowsy: return to AWAKE on that edge, with no woke_up pulse.
- State latency: the transition is visible the cycle after the evaluating tick.
- Enable latency: en_inc/en_dec are combinational on the tick cycle and use the pre-transition state.

## Configuration
- STRESS_WAKE_EN defined:
  - In ASLEEP, stress ≥ STRESS_BLOCK on a tick forces an immediate transition to AWAKE with a woke_up pulse, ignoring both MIN_SLEEP and WAKE_LEVEL.
  - This check has priority over the normal wake/count logic.
- STRESS_WAKE_EN undefined: stress is ignored while ASLEEP.

## Test plan
All scenarios use default parameters.
- Reset: hold rst_n=0 for 3 clocks with tick=1 and energy=0 -> state=00; asleep, fell_asleep, woke_up, en_inc, en_dec all 0.
- Fall asleep: energy=0, stress=0, tick every 4 cycles -> 1st tick: en_dec=1 and state→01. 4 further ticks then state→10 with fell_asleep high for 1 cycle. No enable is asserted during DROWSY.
- Drowsy abort: enter DROWSY, then on the 2nd tick set stress=3 -> state→00 with no fell_asleep. Repeat the abort with energy=1 -> same result.
- Minimum sleep: in ASLEEP with energy=3 from entry -> woke_up on the 9th ASLEEP tick, not earlier. en_inc=1 on each of those 9 ticks.
- Late wake: in ASLEEP with energy=2 for 20 ticks -> stays 10 and cnt saturates at 8. Set energy=3 -> wakes on the next tick.
- Stress wake: ASLEEP, 2 ticks in, stress=3 -> with STRESS_WAKE_EN: state→00 and woke_up pulse. Without it: remains 10.
